// File: rtl/led_pkg.sv
// Shared definitions for the LED shifter and its bounce monitor.
// State encoding, pattern width and the shifter's reset pattern.
package led_pkg;

   localparam int LED_WIDTH = 8;

   localparam logic [LED_WIDTH-1:0] LED_RESET_PATTERN = 8'h01;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TRACK = 2'd1,
      FAULT = 2'd2
   } led_state_t;

endpackage

// File: rtl/led_onehot_enc.sv
// One-hot pattern encoder: index of the set bit plus a legality flag.
// Index is only meaningful while onehot_ok is high.
module led_onehot_enc #(
   parameter int WIDTH = 8,
   parameter int IDX_W = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] pat,
   output logic [IDX_W-1:0] idx,
   output logic             onehot_ok
);

   // Priority-free encode; a single set bit yields its position.
   always_comb begin
      idx = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (pat[i]) idx = IDX_W'(i);
      end
   end

   // Exactly one bit set: nonzero and clearing the lowest bit leaves zero.
   always_comb begin
      onehot_ok = (pat != '0) &&
                  ((pat & (pat - WIDTH'(1))) == '0);
   end

endmodule

// File: rtl/led_bounce_monitor.sv
// Bouncing-LED pattern checker: tracks position/direction, counts
// end-of-travel turns and raises a sticky error on any bad step.
module led_bounce_monitor
   import led_pkg::*;
#(
   parameter int WIDTH = LED_WIDTH,
   parameter int IDX_W = $clog2(WIDTH),
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rs,
   input  logic             en,
   input  logic [WIDTH-1:0] q_in,
   output logic [IDX_W-1:0] pos,
   output logic             dir,
   output logic             bounce,
   output logic [CNT_W-1:0] bounce_cnt,
   output logic             locked,
   output logic             err
);

   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(WIDTH - 1);
   localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [WIDTH-1:0] RELOCK_PAT = WIDTH'(LED_RESET_PATTERN);

   led_state_t       state;
   logic [WIDTH-1:0] prev;
   logic [IDX_W-1:0] enc_idx;
   logic             enc_ok;
   logic [IDX_W-1:0] exp_idx;
   logic             wrap;
   logic             step_ok;

   led_onehot_enc #(
      .WIDTH (WIDTH),
      .IDX_W (IDX_W)
   ) u_enc (
      .pat       (q_in),
      .idx       (enc_idx),
      .onehot_ok (enc_ok)
   );

   // Expected next index; end-of-travel wrap is never a valid step.
   always_comb begin
      exp_idx = dir ? (pos - IDX_ONE) : (pos + IDX_ONE);
      wrap    = (dir && (pos == '0)) ||
                (!dir && (pos == IDX_MAX));
      step_ok = enc_ok && !wrap && (enc_idx == exp_idx);
   end

   // Tracking FSM with registered outputs; rs overrides en.
   always_ff @(posedge clk) begin
      if (rs) begin
         state      <= IDLE;
         prev       <= '0;
         pos        <= '0;
         dir        <= 1'b0;
         bounce     <= 1'b0;
         bounce_cnt <= '0;
         locked     <= 1'b0;
         err        <= 1'b0;
      end else begin
         bounce <= 1'b0;
         if (en) begin
            unique case (state)
               IDLE: begin
                  if (enc_ok) begin
                     pos    <= enc_idx;
                     dir    <= (enc_idx == IDX_MAX);
                     prev   <= q_in;
                     locked <= 1'b1;
                     state  <= TRACK;
                  end else begin
                     err   <= 1'b1;
                     state <= FAULT;
                  end
               end
               TRACK: begin
                  if (q_in == prev) begin
                     state <= TRACK;
                  end else if (step_ok) begin
                     pos  <= enc_idx;
                     prev <= q_in;
                     if (enc_idx == IDX_MAX || enc_idx == '0) begin
                        dir    <= (enc_idx == IDX_MAX);
                        bounce <= 1'b1;
                        if (bounce_cnt != '1)
                           bounce_cnt <= bounce_cnt + CNT_ONE;
                     end
                  end else begin
                     err    <= 1'b1;
                     locked <= 1'b0;
                     state  <= FAULT;
                  end
               end
               FAULT: begin
                  if (q_in == RELOCK_PAT) begin
                     pos    <= '0;
                     dir    <= 1'b0;
                     prev   <= q_in;
                     locked <= 1'b1;
                     state  <= TRACK;
                  end
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_led_bounce_monitor.sv
// Directed vector bench for led_bounce_monitor.
// Second instance with a 2-bit counter exercises saturation.
module tb_led_bounce_monitor;

   logic       clk = 1'b0;
   logic       rs;
   logic       en;
   logic [7:0] q_in;

   logic [2:0] pos, pos2;
   logic       dir, dir2;
   logic       bounce, bounce2;
   logic [7:0] cnt;
   logic [1:0] cnt2;
   logic       locked, locked2;
   logic       err, err2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   led_bounce_monitor dut (
      .clk        (clk),
      .rs         (rs),
      .en         (en),
      .q_in       (q_in),
      .pos        (pos),
      .dir        (dir),
      .bounce     (bounce),
      .bounce_cnt (cnt),
      .locked     (locked),
      .err        (err)
   );

   led_bounce_monitor #(.CNT_W(2)) dut2 (
      .clk        (clk),
      .rs         (rs),
      .en         (en),
      .q_in       (q_in),
      .pos        (pos2),
      .dir        (dir2),
      .bounce     (bounce2),
      .bounce_cnt (cnt2),
      .locked     (locked2),
      .err        (err2)
   );

   typedef struct {
      string      name;
      logic       rs;
      logic       en;
      logic [7:0] q;
      logic [2:0] pos;
      logic       dir;
      logic       bnc;
      logic [7:0] cnt;
      logic       lk;
      logic       er;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(string n, logic r, logic e,
                               logic [7:0] q, logic [2:0] p,
                               logic d, logic b, logic [7:0] c,
                               logic l, logic x);
      vec_t v;
      v.name = n; v.rs = r; v.en = e; v.q = q;
      v.pos = p; v.dir = d; v.bnc = b; v.cnt = c;
      v.lk = l; v.er = x;
      tbl.push_back(v);
   endfunction

   task automatic drive(logic r, logic e, logic [7:0] q);
      rs = r; en = e; q_in = q;
      @(posedge clk);
      #1;
   endtask

   task automatic check(string n, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", n, act, req);
      end
   endtask

   int pulses;

   initial begin
      rs = 1'b1; en = 1'b0; q_in = 8'h00;

      // reset state
      add("reset",      1,0,8'h00, 0,0,0,0, 0,0);
      // full sweep up and back
      for (int i = 0; i < 8; i++)
         add("sweep_up", 0,1,8'(1 << i), 3'(i),
             i == 7, i == 7, (i == 7) ? 8'd1 : 8'd0, 1,0);
      for (int i = 6; i >= 0; i--)
         add("sweep_dn", 0,1,8'(1 << i), 3'(i),
             i != 0, i == 0, (i == 0) ? 8'd2 : 8'd1, 1,0);
      // rs beats en
      add("rs_prio",    1,1,8'h01, 0,0,0,0, 0,0);
      // lock at MSB
      add("lock_msb",   0,1,8'h80, 7,1,0,0, 1,0);
      add("msb_next",   0,1,8'h40, 6,1,0,0, 1,0);
      // skipped step -> fault, relock
      add("rs_c",       1,0,8'h00, 0,0,0,0, 0,0);
      add("c_01",       0,1,8'h01, 0,0,0,0, 1,0);
      add("c_02",       0,1,8'h02, 1,0,0,0, 1,0);
      add("c_04",       0,1,8'h04, 2,0,0,0, 1,0);
      add("c_08",       0,1,8'h08, 3,0,0,0, 1,0);
      add("skip",       0,1,8'h20, 3,0,0,0, 0,1);
      add("fault_04",   0,1,8'h04, 3,0,0,0, 0,1);
      add("relock",     0,1,8'h01, 0,0,0,0, 1,1);
      add("after_rl",   0,1,8'h02, 1,0,0,0, 1,1);
      // illegal in IDLE, then hold
      add("rs_d",       1,0,8'h00, 0,0,0,0, 0,0);
      add("idle_00",    0,1,8'h00, 0,0,0,0, 0,1);
      add("fault_18",   0,1,8'h18, 0,0,0,0, 0,1);
      add("rs_d2",      1,0,8'h00, 0,0,0,0, 0,0);
      add("lock_04",    0,1,8'h04, 2,0,0,0, 1,0);
      for (int i = 0; i < 5; i++)
         add("hold_04", 0,1,8'h04, 2,0,0,0, 1,0);
      // en gating
      add("rs_e",       1,0,8'h00, 0,0,0,0, 0,0);
      add("e_01",       0,1,8'h01, 0,0,0,0, 1,0);
      for (int i = 0; i < 3; i++)
         add("en_low",  0,0,8'h02, 0,0,0,0, 1,0);
      add("e_02",       0,1,8'h02, 1,0,0,0, 1,0);
      for (int i = 2; i < 8; i++)
         add("e_up",    0,1,8'(1 << i), 3'(i),
             i == 7, i == 7, (i == 7) ? 8'd1 : 8'd0, 1,0);
      add("en_low_bnc", 0,0,8'h40, 7,1,0,1, 1,0);
      add("hold_80",    0,1,8'h80, 7,1,0,1, 1,0);
      add("wrong_dir",  0,1,8'h20, 7,1,0,1, 0,1);

      foreach (tbl[k]) begin
         drive(tbl[k].rs, tbl[k].en, tbl[k].q);
         check(tbl[k].name,
               32'({pos, dir, bounce, cnt, locked, err}),
               32'({tbl[k].pos, tbl[k].dir, tbl[k].bnc,
                    tbl[k].cnt, tbl[k].lk, tbl[k].er}));
      end

      // saturation: five turns on both counter widths
      drive(1, 0, 8'h00);
      drive(0, 1, 8'h01);
      pulses = 0;
      for (int b = 0; b < 5; b++) begin
         for (int s = 1; s < 8; s++) begin
            drive(0, 1, 8'(1 << ((b % 2 == 0) ? s : 7 - s)));
            if (bounce2) pulses++;
         end
      end
      check("cnt_wide", 32'(cnt), 32'd5);
      check("cnt_sat", 32'(cnt2), 32'd3);
      check("sat_pulses", pulses, 5);
      check("sat_err", 32'({err2, locked2}), 32'b01);

      // rs mid-sweep
      drive(0, 1, 8'h40);
      check("mid_pos", 32'(pos2), 32'd6);
      drive(1, 1, 8'h20);
      check("rs_mid",
            32'({pos2, dir2, bounce2, cnt2, locked2, err2}), 32'd0);
      check("rs_mid_w",
            32'({pos, dir, bounce, cnt, locked, err}), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
